mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus (same addr/wdata/mem_wr/rd_wr_mem signalling the core drives into data memory).
- The core writes bytes into a TX FIFO with stores, polls status with loads, and the block serialises each byte 8N1 on a `tx` pin.
- It sits beside data memory behind the core's address decode, which supplies `sel`.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of register 0; only addr[3:0] is decoded, `sel` qualifies the rest.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 16'd434, reset value of BAUD_DIV (clock cycles per bit).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- sel  input  1  bus select from address decode.
- addr  input  32  byte address from the core's ALU result.
- wdata  input  32  store data.
- mem_wr  input  1  store strobe.
- rd_wr_mem  input  3  access type, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  output  32  load data; combinational; 0 when sel=0.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (reset=0, async):
  - tx=1, FIFO empty, FSM IDLE.
  - BAUD_DIV=DEFAULT_DIV, CTRL=0, overflow flag=0.
  - Reset mid-frame aborts the frame immediately and drives tx=1.
- Register map (offset = addr[3:0] & 4'hC):
  - 0x0 TXDATA, write only; reads 0.
  - 0x4 STATUS, R/W1C:
    - bit0 full, bit1 empty, bit2 busy (FSM≠IDLE), bit3 overflow (sticky).
    - [11:8] FIFO count; other bits 0.
  - 0x8 BAUD_DIV, R/W, [15:0].
  - 0xC CTRL, R/W, bit0 tx_enable.
- Writes:
  - Take effect on the rising clock edge when sel=1 and mem_wr=1.
  - Width B/H/W is ignored; data is taken from wdata bit 0 upward.
  - TXDATA push uses wdata[7:0].
  - Writing 1 to STATUS bit3 clears overflow.
- Loads:
  - Combinational, side-effect free.
  - The register word is shifted by addr[1:0]*8, then formatted per rd_wr_mem: B/H sign-extend, BU/HU zero-extend, W raw.
- FIFO push:
  - A push when count==FIFO_DEPTH is dropped and sets overflow.
  - A push and a pop in the same cycle are both honoured unless the FIFO is full before the edge; in that case the push is dropped.
- FSM states: IDLE → START → DATA → STOP → IDLE/START.
  - IDLE: when CTRL.tx_enable=1 and FIFO not empty, pop the head into the shift register and go to START on the next edge.
  - START: tx=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each; a 3-bit index counts 0..7.
  - STOP: tx=1 for one bit period. Then go to START with an immediate pop if enabled and the FIFO is not empty, else go to IDLE.
- Bit period:
  - Equals BAUD_DIV clock cycles; BAUD_DIV=0 is treated as 1.
  - A 16-bit counter reloads at each bit boundary.
  - A BAUD_DIV write mid-bit takes effect at the next bit boundary.
- Clearing tx_enable mid-frame: the current frame completes and no further pop occurs.
- Latency: the first tx falling edge occurs 2 cycles after the TXDATA store edge when the block is enabled and idle.

Optional Feature:
- Macro UART_TX_IRQ_EN.
- When defined:
  - Adds output `irq` (1 bit, reset 0, registered).
  - Adds CTRL bit1 irq_enable.
  - irq = irq_enable & empty & ~busy; it is a level, cleared by a push or by clearing irq_enable.
- When undefined: no `irq` port, and CTRL bit1 reads 0 and ignores writes.

Decomposition:
- Package uart_tx_pkg holds:
  - register offset localparams (TXDATA_OFF, STATUS_OFF, BAUD_OFF, CTRL_OFF);
  - STATUS bit index constants;
  - tx_state_t enum {IDLE, START, DATA, STOP};
  - funct3 load encodings shared with the core's load formatting.
- One sub-module, sync_fifo: parameterised width/depth; push/pop/full/empty/count; async active-low reset.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release → tx=1, STATUS read (LW off 0x4) = 32'h0000_0002, BAUD_DIV reads 434.
- Single byte: BAUD_DIV=4, CTRL=1, SW 0xA5 to TXDATA → tx shows 0,1,0,1,0,0,1,0,1,1, each for 4 cycles, starting 2 cycles after the store; then busy=0 and empty=1.
- Overflow: CTRL=0, push 9 bytes (DEPTH 8) → STATUS count=8, full=1, overflow=1. SW 0x8 to STATUS → overflow=0, and count stays 8.
- Back-to-back: CTRL=1, BAUD_DIV=2, push 0x00,0xFF → two frames with exactly one stop bit (2 cycles) between them and no idle gap.
- Load formatting: BAUD_DIV=16'h80F0 → LH off 0x8 = 32'hFFFF_80F0, LHU = 32'h0000_80F0, LB off 0x9 = 32'hFFFF_FF80.
- Mid-frame: with BAUD_DIV=8, assert reset during DATA bit 3 → tx=1 immediately and FIFO empty. In a separate run, clear CTRL mid-frame → the frame finishes and the next queued byte stays in the FIFO.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - register map, status bits, FSM states and load formatting for mmio_uart_tx
package uart_tx_pkg;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] BAUD_OFF   = 4'h8;
  localparam logic [3:0] CTRL_OFF   = 4'hC;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Same lane shift and extension the core applies to data-memory loads.
  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {lane, 3'b000};
    case (f3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_BU:   r = {24'b0, s[7:0]};
      F3_HU:   r = {16'b0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO; a push while full is dropped even if a pop happens that cycle
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter; UART_TX_IRQ_EN adds irq output and CTRL.irq_enable
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic [2:0]  rd_wr_mem,
  output logic [31:0] rdata,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);
  import uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic [15:0] r_baud_div;
  logic        r_tx_en;
  logic        r_ovf;
  logic        r_irq_en;

  logic          w_wr;
  logic [3:0]    w_off;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_count_ext;
  logic [15:0]   w_div_m1;
  logic          w_boundary;
  logic [31:0]   w_status;
  logic [31:0]   w_reg;
  logic          w_unused_bits;

  assign w_wr        = sel & mem_wr;
  assign w_off       = addr[3:0] & 4'hC;
  assign w_push      = w_wr && (w_off == TXDATA_OFF);
  assign w_div_m1    = (r_baud_div == 16'd0) ? 16'd0 : r_baud_div - 16'd1;
  assign w_boundary  = (r_cnt == 16'd0);
  assign w_pop       = r_tx_en && !w_empty &&
                       ((r_state == IDLE) || (r_state == STOP && w_boundary));
  assign w_count_ext = 32'(w_count);
  assign tx          = r_tx;
  assign w_unused_bits = ^{addr[31:4], wdata[31:16], BASE_ADDR};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (wdata[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // tx follows the state one cycle later, giving the 2-cycle store-to-start latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_cnt   <= w_div_m1;
            r_state <= START;
          end
        end
        START: begin
          if (w_boundary) begin
            r_cnt     <= w_div_m1;
            r_bit_idx <= 3'd0;
            r_state   <= DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        DATA: begin
          if (w_boundary) begin
            r_cnt   <= w_div_m1;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'd7) r_state <= STOP;
            else r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        STOP: begin
          if (w_boundary) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_cnt   <= w_div_m1;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_baud_div <= DEFAULT_DIV;
      r_tx_en    <= 1'b0;
      r_ovf      <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (w_wr && w_off == STATUS_OFF && wdata[ST_OVF]) r_ovf <= 1'b0;
      if (w_wr && w_off == BAUD_OFF) r_baud_div <= wdata[15:0];
      if (w_wr && w_off == CTRL_OFF) begin
        r_tx_en <= wdata[0];
`ifdef UART_TX_IRQ_EN
        r_irq_en <= wdata[1];
`endif
      end
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else r_irq <= r_irq_en & w_empty & (r_state == IDLE);
  end
  assign irq = r_irq;
`endif

  always_comb begin
    w_status = 32'd0;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_BUSY]  = (r_state != IDLE);
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_CNT_LSB +: 4] = w_count_ext[3:0];
  end

  always_comb begin
    w_reg = 32'd0;
    case (w_off)
      STATUS_OFF: w_reg = w_status;
      BAUD_OFF:   w_reg = {16'd0, r_baud_div};
      CTRL_OFF:   w_reg = {30'd0, r_irq_en, r_tx_en};
      default:    w_reg = 32'd0;
    endcase
  end

  assign rdata = sel ? load_format(w_reg, addr[1:0], rd_wr_mem) : 32'd0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed bench with a byte/line-level model of mmio_uart_tx
module tb_mmio_uart_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_wr = 1'b0;
  logic [2:0]  rd_wr_mem = 3'b010;
  logic [31:0] rdata;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  mmio_uart_tx dut (
    .clock     (clock),
    .reset     (reset),
    .sel       (sel),
    .addr      (addr),
    .wdata     (wdata),
    .mem_wr    (mem_wr),
    .rd_wr_mem (rd_wr_mem),
    .rdata     (rdata),
    .tx        (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clock = ~clock;

  // Model: expected tx level per sampled cycle, grouped into one chunk per transmitted byte.
  bit         line[$];
  int         chunk[$];
  logic [7:0] chunk_byte[$];
  logic [7:0] m_fifo[$];
  bit         m_ovf;
  bit         m_en;
  int         m_div;
  int         a5_exp[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    line.delete();
    chunk.delete();
    chunk_byte.delete();
    m_fifo.delete();
    m_ovf = 0;
    m_en  = 0;
    m_div = 434;
  endfunction

  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic void model_push(input logic [7:0] b);
    int n;
    if (m_en) begin
      n = 10 * m_div;
      if (line.size() == 0) begin
        line.push_back(1'b1);
        line.push_back(1'b1);
        n += 2;
      end
      for (int k = 0; k < 10; k++)
        for (int r = 0; r < m_div; r++) line.push_back(frame_bit(b, k));
      chunk.push_back(n);
      chunk_byte.push_back(b);
    end else if (m_fifo.size() == 8) begin
      m_ovf = 1;
    end else begin
      m_fifo.push_back(b);
    end
  endfunction

  function automatic void model_ctrl(input bit en);
    int n;
    m_en = en;
    if (!en) begin
      while (chunk.size() > 1) begin
        n = chunk.pop_back();
        repeat (n) void'(line.pop_back());
        m_fifo.push_front(chunk_byte.pop_back());
      end
    end
  endfunction

  function automatic logic [31:0] exp_status();
    int n;
    n = m_fifo.size();
    return (32'(n) << 8) | (m_ovf ? 32'h8 : 32'h0) |
           ((n == 0) ? 32'h2 : 32'h0) | ((n == 8) ? 32'h1 : 32'h0);
  endfunction

  always @(posedge clock) begin
    bit e;
    #1;
    if (!reset) begin
      check("tx_in_reset", 32'(tx), 32'd1);
    end else begin
      e = 1'b1;
      if (line.size() > 0) begin
        e = line.pop_front();
        chunk[0] = chunk[0] - 1;
        if (chunk[0] == 0) begin
          void'(chunk.pop_front());
          void'(chunk_byte.pop_front());
        end
      end
      check("tx_line", 32'(tx), 32'(e));
    end
  end

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] d);
    sel = 1'b1;
    addr = 32'h0000_1000 + off;
    wdata = d;
    mem_wr = 1'b1;
    rd_wr_mem = 3'b010;
    case (off[3:0] & 4'hC)
      4'h0: model_push(d[7:0]);
      4'h4: if (d[3]) m_ovf = 0;
      4'h8: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
      default: model_ctrl(d[0]);
    endcase
    @(negedge clock);
    sel = 1'b0;
    mem_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] off, input logic [2:0] f3, input logic s,
                        output logic [31:0] d);
    sel = s;
    addr = 32'h0000_1000 + off;
    rd_wr_mem = f3;
    mem_wr = 1'b0;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    bus_rd(32'h4, 3'b010, 1'b1, d);
    check("reset_status", d, 32'h0000_0002);
    check("reset_status_model", d, exp_status());
    bus_rd(32'h8, 3'b010, 1'b1, d);
    check("reset_baud", d, 32'd434);

    bus_wr(32'h8, 32'd4);
    bus_wr(32'hC, 32'd1);
    bus_wr(32'h0, 32'hA5);
    for (int k = 1; k <= 43; k++) begin
      @(posedge clock);
      #1;
      if (k < 2 || k >= 42) check("a5_idle", 32'(tx), 32'd1);
      else check("a5_bit", 32'(tx), 32'(a5_exp[(k-2)/4]));
    end
    @(negedge clock);
    bus_rd(32'h4, 3'b010, 1'b1, d);
    check("a5_done_status", d, 32'h0000_0002);
    check("a5_done_model", d, exp_status());

    bus_wr(32'h8, 32'd2);
    bus_wr(32'h0, 32'h00);
    bus_wr(32'h0, 32'hFF);
    for (int k = 2; k <= 24; k++) begin
      @(posedge clock);
      #1;
      case (k)
        19:      check("b2b_last_data", 32'(tx), 32'd0);
        20, 21:  check("b2b_stop", 32'(tx), 32'd1);
        22, 23:  check("b2b_start2", 32'(tx), 32'd0);
        24:      check("b2b_data2", 32'(tx), 32'd1);
        default: ;
      endcase
    end
    @(negedge clock);
    repeat (30) @(negedge clock);
    bus_rd(32'h4, 3'b010, 1'b1, d);
    check("b2b_done_status", d, exp_status());

    do_reset();
    for (int i = 0; i < 9; i++) bus_wr(32'h0, 32'(8'h10 + i));
    bus_rd(32'h4, 3'b010, 1'b1, d);
    check("ovf_status", d, 32'h0000_0809);
    check("ovf_status_model", d, exp_status());
    bus_wr(32'h4, 32'h8);
    bus_rd(32'h4, 3'b010, 1'b1, d);
    check("ovf_clear", d, 32'h0000_0801);
    check("ovf_clear_model", d, exp_status());

    bus_wr(32'h8, 32'h80F0);
    bus_rd(32'h8, 3'b001, 1'b1, d);
    check("lh_baud", d, 32'hFFFF_80F0);
    bus_rd(32'h8, 3'b101, 1'b1, d);
    check("lhu_baud", d, 32'h0000_80F0);
    bus_rd(32'h9, 3'b000, 1'b1, d);
    check("lb_baud_hi", d, 32'hFFFF_FF80);
    bus_rd(32'h9, 3'b100, 1'b1, d);
    check("lbu_baud_hi", d, 32'h0000_0080);
    bus_rd(32'h0, 3'b010, 1'b1, d);
    check("txdata_reads_zero", d, 32'h0);
    bus_rd(32'h8, 3'b010, 1'b0, d);
    check("unselected_zero", d, 32'h0);

    do_reset();
    bus_wr(32'h8, 32'd8);
    bus_wr(32'hC, 32'd1);
    bus_wr(32'h0, 32'h00);
    bus_wr(32'h0, 32'h55);
    repeat (36) @(negedge clock);
    check("mid_bit3_low", 32'(tx), 32'd0);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_reset_tx", 32'(tx), 32'd1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bus_rd(32'h4, 3'b010, 1'b1, d);
    check("mid_reset_status", d, 32'h0000_0002);

    bus_wr(32'h8, 32'd8);
    bus_wr(32'hC, 32'd1);
    bus_wr(32'h0, 32'h3C);
    bus_wr(32'h0, 32'hC3);
    repeat (20) @(negedge clock);
    bus_wr(32'hC, 32'd0);
    repeat (120) @(negedge clock);
    bus_rd(32'h4, 3'b010, 1'b1, d);
    check("ctrl_clear_status", d, 32'h0000_0100);
    check("ctrl_clear_model", d, exp_status());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
